// File: rtl/riscv_stream_loader.sv
// Framed byte-stream program loader. It parses LEN, the payload and CSUM, and
// writes little-endian 32-bit words to instruction memory.
module riscv_stream_loader #(
  parameter int unsigned            MEM_ADDR_W     = 10,
  parameter logic [MEM_ADDR_W-1:0]  BASE_ADDR      = '0,
  parameter int unsigned            MAX_WORDS      = 1024,
  parameter int unsigned            TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  reload,
  output logic                  mem_we,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_rst,
  output logic                  loading_complete,
  output logic                  err,
  output logic [1:0]            err_code
);

  typedef enum logic [2:0] {
    S_HDR0, S_HDR1, S_DATA, S_CSUM, S_DONE, S_ERROR
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [15:0]           idx_q, idx_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [23:0]           asm_q, asm_d;
  logic [7:0]            sum_q, sum_d;
  logic [31:0]           tmo_q, tmo_d;
  logic                  in_ready_q, in_ready_d;
  logic                  mem_we_q, mem_we_d;
  logic [MEM_ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [1:0]            err_code_q, err_code_d;

  logic                  accept;
  logic [15:0]           hdr_len;
  logic [31:0]           tmo_inc;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    byte_cnt_d  = byte_cnt_q;
    asm_d       = asm_q;
    sum_d       = sum_q;
    tmo_d       = tmo_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_code_d  = err_code_q;

    accept  = in_valid && in_ready_q;
    hdr_len = {in_data, len_q[7:0]};
    tmo_inc = tmo_q + 32'd1;

    // An accepted byte clears the idle counter, so a byte in the expiry cycle wins.
    if ((state_q == S_HDR1 || state_q == S_DATA || state_q == S_CSUM) && !accept) begin
      tmo_d = tmo_inc;
      if (tmo_inc >= TIMEOUT_CYCLES) begin
        state_d    = S_ERROR;
        err_code_d = 2'd3;
      end
    end

    unique case (state_q)
      S_HDR0: begin
        tmo_d = '0;
        if (accept) begin
          len_d[7:0] = in_data;
          state_d    = S_HDR1;
        end
      end
      S_HDR1: begin
        if (accept) begin
          tmo_d = '0;
          len_d = hdr_len;
          if (32'(hdr_len) > MAX_WORDS) begin
            state_d    = S_ERROR;
            err_code_d = 2'd2;
          end else if (hdr_len == 16'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          tmo_d      = '0;
          sum_d      = sum_q + in_data;
          asm_d      = {in_data, asm_q[23:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = BASE_ADDR + MEM_ADDR_W'(idx_q);
            mem_wdata_d = {in_data, asm_q};
            idx_d       = idx_q + 16'd1;
            if (idx_q == len_q - 16'd1) state_d = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        if (accept) begin
          tmo_d = '0;
          if (in_data == sum_q) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_ERROR;
            err_code_d = 2'd1;
          end
        end
      end
      S_DONE, S_ERROR: begin
        if (reload) begin
          state_d    = S_HDR0;
          sum_d      = '0;
          idx_d      = '0;
          byte_cnt_d = '0;
          tmo_d      = '0;
          err_code_d = '0;
        end
      end
      default: state_d = S_HDR0;
    endcase

    // Status flags are registered from the next state so they line up with it.
    in_ready_d = (state_d != S_DONE) && (state_d != S_ERROR);
    done_d     = (state_d == S_DONE);
    err_d      = (state_d == S_ERROR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_HDR0;
      len_q       <= '0;
      idx_q       <= '0;
      byte_cnt_q  <= '0;
      asm_q       <= '0;
      sum_q       <= '0;
      tmo_q       <= '0;
      in_ready_q  <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      byte_cnt_q  <= byte_cnt_d;
      asm_q       <= asm_d;
      sum_q       <= sum_d;
      tmo_q       <= tmo_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign in_ready         = in_ready_q;
  assign mem_we           = mem_we_q;
  assign mem_addr         = mem_addr_q;
  assign mem_wdata        = mem_wdata_q;
  assign loading_complete = done_q;
  assign cpu_rst          = ~done_q;
  assign err              = err_q;
  assign err_code         = err_code_q;

endmodule
